// File: rtl/wave_capture_wr.sv
// wave_capture_wr: decimates a sample stream, waits for a rising trigger crossing and writes one frame to the sample RAM
// Ports: clk, rst_n (async active-low); sample_in/sample_vld input stream; trig_level threshold;
//   frame_start display-frame pulse; ram_wr_en/ram_wr_addr/ram_wr_data RAM write port (registered, latency 1);
//   busy (WAIT_TRIG or CAPTURE); capture_done (pulse with the final write of a frame).
// Optional: define WAVE_CAPTURE_AUTO_TRIG_EN to force a trigger after TIMEOUT accepted samples without a crossing.
module wave_capture_wr #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 12,
   parameter int DECIM   = 1,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_vld,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              frame_start,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic              busy,
   output logic              capture_done
);
   localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   typedef enum logic [1:0] {ARM, WAIT_TRIG, CAPTURE, HOLD} state_t;
   state_t            r_state, w_next;
   logic [DCW-1:0]    r_dcnt;
   logic [DATA_W-1:0] r_prev;
   logic              r_prev_vld;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wr_en, r_done;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              w_run, w_acc, w_cross, w_trig, w_cap, w_last;
   assign w_run   = (r_state == WAIT_TRIG) || (r_state == CAPTURE);
   assign w_acc   = w_run && sample_vld && (r_dcnt == '0);
   assign w_cross = r_prev_vld && (r_prev < trig_level) && (sample_in >= trig_level);
   assign w_cap   = (r_state == CAPTURE) && w_acc;
   assign w_last  = w_cap && (&r_addr);
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] r_tcnt;
   // r_tcnt holds the number of accepted samples already seen, so the TIMEOUT-th one forces the trigger
   assign w_trig = w_acc && (r_state == WAIT_TRIG) && (w_cross || (r_tcnt == TW'(TIMEOUT - 1)));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_tcnt <= '0;
      else if (r_state == ARM) r_tcnt <= '0;
      else if (w_acc && (r_state == WAIT_TRIG)) r_tcnt <= r_tcnt + 1'b1;
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT == 0);
   assign w_trig = w_acc && (r_state == WAIT_TRIG) && w_cross;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ARM;
      else r_state <= w_next;
   end
   // r_done marks the cycle of the final write; a frame_start seen then is dropped
   always_comb begin
      w_next = r_state;
      case (r_state)
         ARM:       w_next = WAIT_TRIG;
         WAIT_TRIG: w_next = w_trig ? CAPTURE : WAIT_TRIG;
         CAPTURE:   w_next = w_last ? HOLD : CAPTURE;
         HOLD:      w_next = (frame_start && !r_done) ? ARM : HOLD;
         default:   w_next = ARM;
      endcase
   end
   always_comb begin
      busy         = w_run;
      ram_wr_en    = r_wr_en;
      ram_wr_addr  = r_wr_addr;
      ram_wr_data  = r_wr_data;
      capture_done = r_done;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en    <= 1'b0;
         r_done     <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_addr     <= '0;
         r_dcnt     <= '0;
         r_prev     <= '0;
         r_prev_vld <= 1'b0;
      end else begin
         r_wr_en <= w_trig || w_cap;
         r_done  <= w_last;
         if (w_trig || w_cap) begin
            r_wr_addr <= w_trig ? '0 : r_addr;
            r_wr_data <= sample_in;
            r_addr    <= w_trig ? ADDR_W'(1) : r_addr + 1'b1;
         end
         if (r_state == ARM) begin
            r_dcnt     <= '0;
            r_prev_vld <= 1'b0;
         end else if (w_run && sample_vld) begin
            r_dcnt <= (r_dcnt == DCW'(DECIM - 1)) ? '0 : r_dcnt + 1'b1;
         end
         if (w_acc && (r_state == WAIT_TRIG) && !w_trig) begin
            r_prev     <= sample_in;
            r_prev_vld <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_wave_capture_wr.sv
// tb_wave_capture_wr: two instances (DECIM 1 and 4) fed one stream, checked by a queue scoreboard against a frame-level model
module tb_wave_capture_wr;
   localparam int N   = 1024;
   localparam int TMO = 16;
   typedef struct {int a; int d; bit done;} exp_t;
   logic        clk = 0, rst_n = 0, s_vld = 0, fs = 0;
   logic [11:0] s_in = 0, lvl = 100;
   logic        wr_en [2];
   logic [9:0]  wr_addr [2];
   logic [11:0] wr_data [2];
   logic        busy [2];
   logic        done [2];
   int checks = 0, errors = 0;
   exp_t q [2][$];
   int dk [2] = '{1, 4};
   int ph [2] = '{0, 0};
   int nval [2], prev [2], hp [2], nad [2], wc [2], fresh [2];
   int a0 [2] = '{-1, -1};
   int last [2] = '{-1, -1};
   int nwr [2] = '{0, 0};
   always #5 clk = ~clk;
   wave_capture_wr #(.DECIM(1), .TIMEOUT(TMO)) u_d1 (
      .clk(clk), .rst_n(rst_n), .sample_in(s_in), .sample_vld(s_vld), .trig_level(lvl),
      .frame_start(fs), .ram_wr_en(wr_en[0]), .ram_wr_addr(wr_addr[0]), .ram_wr_data(wr_data[0]),
      .busy(busy[0]), .capture_done(done[0]));
   wave_capture_wr #(.DECIM(4), .TIMEOUT(TMO)) u_d4 (
      .clk(clk), .rst_n(rst_n), .sample_in(s_in), .sample_vld(s_vld), .trig_level(lvl),
      .frame_start(fs), .ram_wr_en(wr_en[1]), .ram_wr_addr(wr_addr[1]), .ram_wr_data(wr_data[1]),
      .busy(busy[1]), .capture_done(done[1]));
   // phases: 0 arm, 1 waiting for trigger, 2 capturing, 3 holding the frame
   task automatic model_step(int k);
      bit acc = 0;
      bit auto_t = 0;
      int s = int'(s_in);
      int l = int'(lvl);
      if (s_vld && (ph[k] == 1 || ph[k] == 2)) begin
         acc = (nval[k] % dk[k]) == 0;
         nval[k]++;
      end
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
      auto_t = (wc[k] == TMO - 1);
`endif
      if (ph[k] == 0) begin
         ph[k] = 1; nval[k] = 0; hp[k] = 0; wc[k] = 0;
      end else if (ph[k] == 1) begin
         if (acc) begin
            if ((hp[k] != 0 && prev[k] < l && s >= l) || auto_t) begin
               q[k].push_back('{0, s, 1'b0});
               nad[k] = 1; ph[k] = 2;
            end else begin
               prev[k] = s; hp[k] = 1; wc[k]++;
            end
         end
      end else if (ph[k] == 2) begin
         if (acc) begin
            q[k].push_back('{nad[k], s, nad[k] == N - 1});
            if (nad[k] == N - 1) begin ph[k] = 3; fresh[k] = 1; end
            else nad[k]++;
         end
      end else begin
         if (fs && fresh[k] == 0) ph[k] = 0;
         fresh[k] = 0;
      end
   endtask
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            ph[k] = 0; nval[k] = 0; hp[k] = 0; wc[k] = 0; fresh[k] = 0;
            q[k].delete();
         end
      end else begin
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         checks++;
         if (busy[k] !== (ph[k] == 1 || ph[k] == 2)) begin
            errors++;
            $display("FAIL busy[%0d] t=%0t got %b want %b", k, $time, busy[k], (ph[k] == 1 || ph[k] == 2));
         end
         checks++;
         if (wr_en[k] === 1'b1) begin
            nwr[k]++;
            if (wr_addr[k] == 0) a0[k] = int'(wr_data[k]);
            if (done[k]) last[k] = int'(wr_data[k]);
            if (q[k].size() == 0) begin
               errors++;
               $display("FAIL unexpected_write[%0d] t=%0t got addr %0d data %0d, want no write", k, $time, wr_addr[k], wr_data[k]);
            end else begin
               e = q[k].pop_front();
               if (int'(wr_addr[k]) != e.a || int'(wr_data[k]) != e.d || done[k] !== e.done) begin
                  errors++;
                  $display("FAIL write[%0d] t=%0t got addr %0d data %0d done %b, want addr %0d data %0d done %b",
                           k, $time, wr_addr[k], wr_data[k], done[k], e.a, e.d, e.done);
               end
            end
         end else if (wr_en[k] !== 1'b0 || q[k].size() != 0 || done[k] !== 1'b0) begin
            errors++;
            $display("FAIL missing_write[%0d] t=%0t got en %b done %b, want %0d pending write(s)", k, $time, wr_en[k], done[k], q[k].size());
            q[k].delete();
         end
      end
   end
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask
   task automatic chk_zero(string name);
      for (int k = 0; k < 2; k++)
         chk(name, int'({wr_en[k], busy[k], done[k]}) + int'(wr_addr[k]) + int'(wr_data[k]), 0);
   endtask
   initial begin
      int base, found, mode, step;
      repeat (3) @(negedge clk);
      chk_zero("reset_outputs");
      rst_n = 1;
      // ramp with DECIM 1 capturing 100..1123; frame_start on the final-write cycle must be dropped
      for (int t = 0; t < 1300; t++) begin
         @(negedge clk);
         s_in = 12'(t); s_vld = 1; fs = done[0];
      end
      fs = 0;
`ifndef WAVE_CAPTURE_AUTO_TRIG_EN
      chk("ramp_addr0_data", a0[0], 100);
      chk("ramp_last_data", last[0], 1123);
      chk("ramp_write_count", nwr[0], N);
`endif
      chk("ramp_hold_busy", int'(busy[0]), 0);
      // keep ramping: level change mid-capture, a 10-cycle valid gap, random gaps, frame_start pulses
      for (int t = 1300; t < 6500; t++) begin
         @(negedge clk);
         s_in = 12'(t % 4096);
         s_vld = (t >= 2000 && t < 2010) ? 1'b0 : (t < 2500 || $urandom_range(0, 15) != 0);
         fs = (t == 1350 || t == 5000);
         if (t == 1400) lvl = 200;
      end
      // re-arm, ramp again and reset asynchronously while address 500 is on the bus
      @(negedge clk); fs = 1;
      @(negedge clk); fs = 0;
      found = 0;
      for (int t = 0; t < 3000 && found == 0; t++) begin
         @(negedge clk);
         if (wr_en[0] && wr_addr[0] == 10'd500) found = 1;
         else begin s_in = 12'(t % 4096); s_vld = 1; end
      end
      chk("addr500_reached", found, 1);
      #2 rst_n = 0;
      #1 chk_zero("async_reset_outputs");
      @(negedge clk); rst_n = 1;
      base = nwr[0];
      for (int t = 701; t < 900; t++) begin
         @(negedge clk); s_in = 12'(t); s_vld = 1;
      end
      chk("no_write_without_new_crossing", nwr[0] - base, 0);
      // DC input below the level
      lvl = 100; s_in = 50;
      base = nwr[0];
      repeat (10000) @(negedge clk);
`ifndef WAVE_CAPTURE_AUTO_TRIG_EN
      chk("dc_input_no_write", nwr[0] - base, 0);
`endif
      // input equal to the level never triggers; a step 0 -> 4095 does
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1; lvl = 777; s_in = 777;
      base = nwr[0];
      repeat (3000) @(negedge clk);
`ifndef WAVE_CAPTURE_AUTO_TRIG_EN
      chk("equal_level_no_write", nwr[0] - base, 0);
`endif
      a0[0] = -1;
      s_in = 0;
      repeat (5) @(negedge clk);
      s_in = 4095;
      repeat (10) @(negedge clk);
      chk("step_addr0_data", a0[0], 4095);
      // randomized segments: noise, ramps and constants with random levels, gaps and frame_start pulses
      mode = 0; step = 1;
      for (int t = 0; t < 24000; t++) begin
         @(negedge clk);
         if (t % 500 == 0) begin
            mode = $urandom_range(0, 2);
            step = $urandom_range(1, 40);
            lvl = 12'($urandom_range(0, 4095));
         end
         s_in = (mode == 0) ? 12'($urandom_range(0, 4095)) : (mode == 1) ? 12'((int'(s_in) + step) % 4096) : s_in;
         s_vld = ($urandom_range(0, 5) != 0);
         fs = ($urandom_range(0, 599) == 0);
      end
      s_vld = 0; fs = 0;
      repeat (4) @(negedge clk);
      chk("queue0_drained", q[0].size(), 0);
      chk("queue1_drained", q[1].size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wave_capture_wr.md
Name: wave_capture_wr

Overview:
- Upstream stage of the waveform display path. Sits between the signal generator's 12-bit sample stream and the write port of the 1024x12 dual-port sample RAM; the display-side RAM reader consumes the read port, one address per pixel column.
- Decimates the sample stream and waits for a rising-edge trigger crossing, then writes one frame of 1024 samples.
- Holds the captured frame until the next display frame start, so a frame is never overwritten while it is being drawn.

Parameters:
- ADDR_W, 10, RAM address width; frame length = 2**ADDR_W samples.
- DATA_W, 12, sample width.
- DECIM, 1, keep one sample in every DECIM valid samples. Legal range 1..256.
- TIMEOUT, 4096, auto-trigger timeout in decimated samples. Used only with AUTO_TRIG_EN.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- sample_in, input, DATA_W, unsigned sample from the generator.
- sample_vld, input, 1, sample_in is valid this cycle.
- trig_level, input, DATA_W, trigger threshold (unsigned).
- frame_start, input, 1, one-cycle pulse at the start of a display frame.
- ram_wr_en, output, 1, RAM write enable.
- ram_wr_addr, output, ADDR_W, RAM write address.
- ram_wr_data, output, DATA_W, RAM write data.
- busy, output, 1, high in WAIT_TRIG and CAPTURE.
- capture_done, output, 1, one-cycle pulse when the last sample of a frame is written.

Behaviour:
- Reset: state = ARM. ram_wr_en, ram_wr_addr, ram_wr_data, busy, capture_done, decimation counter, prev-sample register and prev-valid flag all 0. Reset takes effect immediately in any state; a partial frame is abandoned and no further writes occur.
- Decimation: counter counts valid samples 0..DECIM-1. A valid sample is "accepted" when the counter is 0. The counter wraps after DECIM-1. With DECIM=1 every valid sample is accepted. Only accepted samples feed trigger detection and capture.
- ARM (one cycle): clear the prev-valid flag and the decimation counter, then go to WAIT_TRIG.
- WAIT_TRIG:
  - The first accepted sample only loads prev and sets prev-valid.
  - After that, trigger when prev < trig_level and sample_in >= trig_level (unsigned compare). Otherwise prev <= sample_in.
  - The triggering sample is written to address 0. Go to CAPTURE with addr counter = 1.
- CAPTURE:
  - Each accepted sample is written at the addr counter, which then increments.
  - When the sample at address 2**ADDR_W-1 is written, go to HOLD.
  - No wrap-around within a frame.
- Write timing: registered, latency 1. A sample accepted in cycle N gives ram_wr_en=1 in cycle N+1, with ram_wr_addr and ram_wr_data holding that sample's address and value. ram_wr_en is 0 in every other cycle.
- capture_done: pulses high in the same cycle as the final write (address 1023).
- HOLD:
  - No writes.
  - frame_start moves to ARM on the next edge.
  - frame_start in any other state is ignored, not latched.
  - If frame_start arrives in the same cycle as the final CAPTURE write, it is ignored; the FSM waits for the next frame_start.
- busy = 1 in WAIT_TRIG and CAPTURE, 0 in ARM and HOLD.
- A trig_level change mid-capture has no effect on the current frame.
- sample_vld gaps stall the capture; the addr counter and decimation counter hold their values.

Optional Feature:
- Macro: WAVE_CAPTURE_AUTO_TRIG_EN.
- With the macro defined:
  - A timeout counter counts accepted samples in WAIT_TRIG and is cleared in ARM.
  - When it reaches TIMEOUT-1 without a crossing, the current accepted sample is treated as the trigger and written to address 0; capture then proceeds normally.
  - A real crossing on that same sample is indistinguishable and behaves identically.
- Without the macro: no timeout logic. The FSM waits in WAIT_TRIG indefinitely (a DC input never displays).

Test Plan:
1. Reset release, ramp input 0..4095 step 1 every cycle, trig_level=100, DECIM=1 -> first write at addr 0 with data 100 (prev 99 < 100 <= 100); 1024 consecutive writes with data 100..1123; capture_done pulse at addr 1023; then busy=0, no writes.
2. After test 1, frame_start pulse -> ARM then WAIT_TRIG. The ramp must fall below 100 and cross again before the next addr-0 write. A frame_start pulse while busy=1 causes no state change.
3. DECIM=4, ramp step 1, trig_level=200 -> the written data sequence steps by 4. A write occurs only on every 4th valid sample. sample_vld held low for 10 cycles mid-frame -> no writes and no address skip.
4. Constant input 50, trig_level=100: without the macro, no write after 10000 samples. With WAVE_CAPTURE_AUTO_TRIG_EN and TIMEOUT=16, the first write (addr 0, data 50) occurs exactly 1 cycle after the 16th accepted sample.
5. Assert rst_n low while ram_wr_addr=500 in CAPTURE -> all outputs 0 asynchronously. After release, a new capture starts from addr 0 only after a fresh crossing.
6. Input exactly equal to trig_level from the first sample -> no trigger, since prev is never below the level. A step input 0 -> 4095 triggers with addr-0 data 4095.
